mem_stage_sram_ctrl: RTL and testbench

- MEM-stage block directly downstream of the EX stage.
- Takes the EX result (byte address) and the store value (val_rm), and performs 32-bit loads/stores on an external 16-bit-wide SRAM as two halfword accesses.
- Drives `ready` low while an access is in flight, so the hazard/freeze logic stalls PC and the pipeline registers.
- Returns load data to the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit load/store over a 16-bit SRAM as two halfword phases.
// Ports: clk, rst (async, active-low); mem_R_en/mem_W_en/alu_result/val_rm
// from EX/MEM; ready (0 = freeze), read_data to MEM/WB; sram_* SRAM bus.
// Optional MEM_ADDR_CHECK_EN adds addr_err and rejects bad addresses.
module mem_stage_sram_ctrl #(
  parameter int unsigned MEM_BASE      = 1024,
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_R_en,
  input  logic               mem_W_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
`ifdef MEM_ADDR_CHECK_EN
  output logic               addr_err,
`endif
  output logic               sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  localparam int CW = (ACCESS_CYCLES > 1) ?
                      $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(ACCESS_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [15:0]        lo_q, lo_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        diff;
  logic [SRAM_AW-2:0] word_in;
  logic               req;
  logic               start;
  logic               last;
  logic               unused_diff;

  assign diff    = alu_result - MEM_BASE;
  assign word_in = diff[SRAM_AW:2];
  assign unused_diff = ^{diff[31:SRAM_AW+1], diff[1:0]};

  assign req  = mem_R_en | mem_W_en;
  assign last = (cnt_q == CNT_LAST);

`ifdef MEM_ADDR_CHECK_EN
  logic [32:0] lim;
  logic        err;

  assign lim = 33'(MEM_BASE) + (33'd1 << (SRAM_AW + 1));
  assign err = (alu_result < MEM_BASE)
             | ({1'b0, alu_result} >= lim)
             | (alu_result[1:0] != 2'b00);
  assign start = req & ~err;
  // Rejected requests never leave IDLE.
  assign addr_err = (state_q == S_IDLE) & req & err;
`else
  assign start = req;
`endif

  assign ready = ((state_q == S_IDLE) & ~start)
               | (state_q == S_DONE);

  assign read_data = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOW;
          cnt_d   = '0;
          word_d  = word_in;
          wdata_d = val_rm;
          // Store wins when both enables are set.
          wr_d    = mem_W_en;
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          if (!wr_q) lo_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          // read_data only changes once a load completes.
          if (!wr_q) rdata_d = {sram_dq_in, lo_q};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (1'b1)
      (state_q == S_LOW),
      (state_q == S_HIGH): begin
        sram_addr = {word_q, state_q == S_HIGH};
        if (wr_q) begin
          sram_dq_oe  = 1'b1;
          // Strobe released on the last cycle to hold addr/data.
          sram_we_n   = last;
          sram_dq_out = (state_q == S_HIGH) ?
                        wdata_q[31:16] : wdata_q[15:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: random loads/stores vs. a word-level
// memory model, plus reset, boundary and back-to-back cases.
module tb_mem_stage_sram_ctrl;

  localparam int unsigned MEM_BASE = 1024;
  localparam int unsigned AW       = 18;
  localparam int unsigned AC       = 2;
  localparam int          LAT      = 2 * AC + 1;
  localparam int          NHW      = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_R_en = 1'b0;
  logic          mem_W_en = 1'b0;
  logic [31:0]   alu_result = '0;
  logic [31:0]   val_rm = '0;
  logic          ready;
  logic [31:0]   read_data;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;
`ifdef MEM_ADDR_CHECK_EN
  logic          addr_err;
`endif

  mem_stage_sram_ctrl #(
    .MEM_BASE(MEM_BASE),
    .SRAM_AW(AW),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_R_en(mem_R_en),
    .mem_W_en(mem_W_en),
    .alu_result(alu_result),
    .val_rm(val_rm),
    .ready(ready),
    .read_data(read_data),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
`ifdef MEM_ADDR_CHECK_EN
    .addr_err(addr_err),
`endif
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0]   sram_mem [0:NHW-1];
  logic [15:0]   ref_mem  [0:NHW-1];
  int            wcnt = 0;
  int            bad_cnt = 0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [15:0]   pre_d = '0;

  assign sram_dq_in = sram_mem[sram_addr];

  always @(posedge clk) begin
    if (pre_en) begin
      sram_mem[pre_a] <= pre_d;
    end else if (!sram_we_n) begin
      if (sram_dq_oe) begin
        sram_mem[sram_addr] <= sram_dq_out;
        wcnt <= wcnt + 1;
      end else begin
        bad_cnt <= bad_cnt + 1;
      end
    end
  end

  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_rd = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pre(input int a, input logic [15:0] d);
    pre_en = 1'b1;
    pre_a  = AW'(a);
    pre_d  = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic idle_chk();
    chk("idle_rdy", {31'b0, ready}, 32'd1);
    chk("idle_ctl", {30'b0, sram_we_n, sram_dq_oe}, 32'd2);
    chk("idle_adr", 32'(sram_addr), 32'd0);
    chk("idle_dq", 32'(sram_dq_out), 32'd0);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    mem_R_en = 1'b0;
    mem_W_en = 1'b0;
    #1;
    idle_chk();
  endtask

  // One access from the IDLE cycle through DONE; inputs are
  // scrambled once the request has been taken.
  task automatic do_op(input bit wr, input bit rd,
                       input logic [31:0] a,
                       input logic [31:0] d);
    int          cyc;
    int          w0;
    int          hw;
    logic [31:0] w;
    w  = ((a - MEM_BASE) >> 2) & ((32'd1 << (AW - 1)) - 1);
    hw = int'(w) * 2;
    @(posedge clk);
    #1;
    w0 = wcnt;
    mem_W_en   = wr;
    mem_R_en   = rd;
    alu_result = a;
    val_rm     = d;
    #1;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        alu_result = $urandom;
        val_rm     = $urandom;
      end
      #1;
    end
    chk("latency", cyc, LAT);
    if (wr) begin
      ref_mem[hw]     = d[15:0];
      ref_mem[hw + 1] = d[31:16];
      chk("st_wcnt", wcnt - w0, 2 * (AC - 1));
      chk("st_lo", 32'(sram_mem[hw]), 32'(ref_mem[hw]));
      chk("st_hi", 32'(sram_mem[hw + 1]),
          32'(ref_mem[hw + 1]));
    end else begin
      exp_rd = {ref_mem[hw + 1], ref_mem[hw]};
      chk("ld_wcnt", wcnt - w0, 0);
    end
    chk("rdata", read_data, exp_rd);
  endtask

  initial begin
    int          w;
    int          kind;
    logic [31:0] a;

    rst        = 1'b0;
    mem_W_en   = 1'b1;
    alu_result = 32'd1024;
    val_rm     = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {31'b0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst_rd", read_data, 32'd0);
    chk("rst_adr", 32'(sram_addr), 32'd0);
    mem_W_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    idle_chk();

    for (int i = 0; i < 512; i++) pre(i, 16'($urandom));
    pre(NHW - 2, 16'($urandom));
    pre(NHW - 1, 16'($urandom));
    pre(6, 16'h5678);
    pre(7, 16'h1234);
    go_idle();

    do_op(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF);
    chk("beef", 32'(sram_mem[0]), 32'h0000_BEEF);
    chk("dead", 32'(sram_mem[1]), 32'h0000_DEAD);
    go_idle();
    do_op(1'b0, 1'b1, 32'd1036, 32'd0);
    chk("ld_1036", read_data, 32'h1234_5678);
    go_idle();

    do_op(1'b1, 1'b0, 32'd1064, 32'hCAFE_F00D);
    do_op(1'b0, 1'b1, 32'd1064, 32'd0);
    chk("b2b", read_data, 32'hCAFE_F00D);
    do_op(1'b1, 1'b1, 32'd1068, 32'h0BAD_1DEA);
    do_op(1'b0, 1'b1, 32'd1068, 32'd0);
    go_idle();

    do_op(1'b0, 1'b1, MEM_BASE + 4 * ((NHW / 2) - 1), 32'd0);
    do_op(1'b1, 1'b0, 32'd1020, 32'h7777_8888);
    do_op(1'b0, 1'b1, MEM_BASE + 4 * ((NHW / 2) - 1), 32'd0);
    chk("wrap", read_data, 32'h7777_8888);
    go_idle();

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      w    = $urandom_range(0, 255);
      a    = MEM_BASE + 32'(4 * w);
      if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
      do_op(kind != 0, kind != 1, a, $urandom);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    do_op(1'b0, 1'b1, 32'd1052, 32'd0);
    go_idle();
    @(posedge clk);
    #1;
    mem_R_en   = 1'b1;
    alu_result = 32'd1052;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {31'b0, ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_we", {31'b0, sram_we_n}, 32'd1);
    chk("mid_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("mid_rd", read_data, 32'd0);
    chk("mid_adr", 32'(sram_addr), 32'd0);
    exp_rd   = '0;
    mem_R_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    idle_chk();
    do_op(1'b0, 1'b1, 32'd1052, 32'd0);
    go_idle();

    chk("rd_strobe", bad_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
